// File: rtl/rsa_mont_pre.sv
// Montgomery pre-processing: result_o = A * 2^WIDTH mod N via bit-serial shift/conditional-subtract.
// Optional RSA_PRE_RADIX4_EN: two chained steps per CALC cycle, halving the iteration count.
module rsa_mont_pre #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready,
  output logic             busy,
  output logic             beg_pre,
  output logic [1:0]       pre_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef RSA_PRE_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
`else
  localparam int STEPS = WIDTH;
`endif
  localparam int             CW   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(STEPS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] n_q;
  logic [CW-1:0]    cnt;

  // One doubling mod n. The compare is a full WIDTH+1-bit compare of {r,0};
  // the subtract can stay WIDTH bits because the true difference is below n.
  function automatic logic [WIDTH-1:0] mont_step(input logic [WIDTH-1:0] r_in,
                                                 input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] sh;
    logic             ge;
    sh = {r_in[WIDTH-2:0], 1'b0};
    ge = ({r_in, 1'b0} >= {1'b0, n});
    return ge ? (sh - n) : sh;
  endfunction

`ifdef RSA_PRE_RADIX4_EN
  assign r_step = mont_step(mont_step(r, n_q), n_q);
`else
  assign r_step = mont_step(r, n_q);
`endif

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here is plain state (no memory array), so all of it is cleared on reset.
    if (!reset) begin
      state    <= IDLE;
      r        <= '0;
      n_q      <= '0;
      cnt      <= '0;
      result_o <= '0;
      ready    <= 1'b0;
      beg_pre  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state   <= state_next;
      ready   <= (state == DONE);
      beg_pre <= (state == IDLE) && start;
      case (state)
        IDLE: begin
          if (start) begin
            n_q <= n_i;
            r   <= a_i;
            cnt <= '0;
          end
        end
        CALC: begin
          r   <= r_step;
          cnt <= cnt + CW'(1);
        end
        DONE:    result_o <= r;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign pre_state = state;

endmodule

// File: tb/tb_rsa_mont_pre.sv
// Self-checking bench for rsa_mont_pre: WIDTH=8 vector table, corner sequences, WIDTH=256 vectors.
module tb_rsa_mont_pre;

`ifdef RSA_PRE_RADIX4_EN
  localparam int LAT8   = 5;
  localparam int LAT256 = 129;
`else
  localparam int LAT8   = 9;
  localparam int LAT256 = 257;
`endif

  logic         clk;
  logic         reset;
  logic         start8, start256;
  logic [7:0]   n8, a8, res8;
  logic [255:0] n256, a256, res256;
  logic         rdy8, rdy256, busy8, busy256, beg8, beg256;
  logic [1:0]   st8, st256;

  int n_checks = 0;
  int n_err    = 0;

  rsa_mont_pre #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .n_i(n8), .a_i(a8),
    .result_o(res8), .ready(rdy8), .busy(busy8), .beg_pre(beg8), .pre_state(st8)
  );

  rsa_mont_pre #(.WIDTH(256)) dut256 (
    .clk(clk), .reset(reset), .start(start256), .n_i(n256), .a_i(a256),
    .result_o(res256), .ready(rdy256), .busy(busy256), .beg_pre(beg256), .pre_state(st256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [7:0] a;
    logic [7:0] expv;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Start one run on the chosen instance and follow it to completion.
  // disturb_at > 0 pulses start and changes operands for the edge of that cycle.
  task automatic run_vec(input bit wide, input logic [255:0] n, input logic [255:0] a,
                         input logic [255:0] expv, input int lat, input string name,
                         input int disturb_at);
    int ready_at;
    int pulses;
    @(negedge clk);
    if (wide) begin n256 = n; a256 = a; start256 = 1'b1; end
    else begin n8 = n[7:0]; a8 = a[7:0]; start8 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start256 = 1'b0;
    check({name, " beg_pre"}, 256'(wide ? beg256 : beg8), 256'd1);
    check({name, " busy"}, 256'(wide ? busy256 : busy8), 256'd1);
    check({name, " state_calc"}, 256'(wide ? st256 : st8), 256'd1);
    ready_at = -1;
    pulses   = 0;
    for (int k = 1; k <= lat + 3; k++) begin
      if (k == disturb_at) begin
        if (wide) begin start256 = 1'b1; n256 = ~n256; a256 = 256'd7; end
        else begin start8 = 1'b1; n8 = 8'h11; a8 = 8'h07; end
      end
      @(posedge clk); #1;
      start8 = 1'b0; start256 = 1'b0;
      if (wide ? rdy256 : rdy8) begin
        pulses++;
        if (ready_at < 0) ready_at = k;
      end
      if (k == 2) check({name, " no_beg_repeat"}, 256'(wide ? beg256 : beg8), 256'd0);
      if (k == lat - 1) check({name, " state_done"}, 256'(wide ? st256 : st8), 256'd2);
    end
    check({name, " ready_cycle"}, 256'(ready_at), 256'(lat));
    check({name, " ready_pulses"}, 256'(pulses), 256'd1);
    check({name, " result"}, wide ? res256 : {248'd0, res8}, expv);
    check({name, " idle_after"}, 256'(wide ? busy256 : busy8), 256'd0);
  endtask

  vec_t         vecs[8];
  int           bad;
  logic [255:0] big_n, big_a, big_exp;

  initial begin
    vecs[0] = '{n: 8'hBB, a: 8'h05, expv: 8'h9E};
    vecs[1] = '{n: 8'hBB, a: 8'hBA, expv: 8'h76};
    vecs[2] = '{n: 8'hFF, a: 8'h01, expv: 8'h01};
    vecs[3] = '{n: 8'h01, a: 8'h00, expv: 8'h00};
    vecs[4] = '{n: 8'hF1, a: 8'h80, expv: 8'hE9};
    vecs[5] = '{n: 8'h0D, a: 8'h0C, expv: 8'h04};
    vecs[6] = '{n: 8'hFF, a: 8'hFE, expv: 8'hFE};
    vecs[7] = '{n: 8'h03, a: 8'h02, expv: 8'h02};

    reset = 1'b0; start8 = 1'b0; start256 = 1'b0;
    n8 = '0; a8 = '0; n256 = '0; a256 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result8", {248'd0, res8}, 256'd0);
    check("reset busy8", 256'(busy8), 256'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle after reset release: nothing may move without start.
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rdy8 || rdy256 || st8 != 2'd0 || st256 != 2'd0 || beg8 || beg256) bad++;
    end
    check("idle quiet cycles", 256'(bad), 256'd0);
    check("idle result8", {248'd0, res8}, 256'd0);
    check("idle result256", res256, 256'd0);

    foreach (vecs[i])
      run_vec(1'b0, {248'd0, vecs[i].n}, {248'd0, vecs[i].a}, {248'd0, vecs[i].expv},
              LAT8, $sformatf("vec%0d", i), 0);

    // Second start and operand change while busy must be ignored.
    run_vec(1'b0, 256'hBB, 256'h05, 256'h9E, LAT8, "restart_ignored", 3);

    // Async reset in the 4th CALC cycle aborts the run and clears the held result.
    @(negedge clk);
    n8 = 8'hBB; a8 = 8'hBA; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort result", {248'd0, res8}, 256'd0);
    check("abort state", 256'(st8), 256'd0);
    check("abort busy", 256'(busy8), 256'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < LAT8 + 4; k++) begin
      @(posedge clk); #1;
      if (rdy8 || busy8) bad++;
    end
    check("abort no ready", 256'(bad), 256'd0);
    run_vec(1'b0, 256'hFF, 256'h01, 256'h01, LAT8, "after_abort", 0);

    // WIDTH=256: N = 2^256-59, so 2^256 mod N = 59 and 3*59 = 177.
    big_n = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFC5;
    run_vec(1'b1, big_n, 256'd3, 256'd177, LAT256, "w256_small", 0);

    big_n   = 256'hC7A51B3D_9F024E68_A1B2C3D4_E5F60718_293A4B5C_6D7E8F90_12345678_9ABCDEF1;
    big_a   = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    big_exp = 256'(({big_a, 256'd0}) % {256'd0, big_n});
    run_vec(1'b1, big_n, big_a, big_exp, LAT256, "w256_model", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
